// File: rtl/rr_arb_pkg.sv
// Shared constants, FSM state type and helpers for the 8-way round-robin arbiter.
package rr_arb_pkg;

   localparam int unsigned N     = 8;
   localparam int unsigned IDX_W = 3;

   typedef enum logic [0:0] {
      IDLE = 1'b0,
      BUSY = 1'b1
   } state_e;

   // Binary index to one-hot vector
   function automatic logic [N-1:0] onehot(input logic [IDX_W-1:0] idx);
      logic [N-1:0] v;
      v      = '0;
      v[idx] = 1'b1;
      return v;
   endfunction

endpackage

// File: rtl/rr_arbiter8_pick.sv
// Combinational rotating priority encoder: first unmasked request at or after start.
module rr_pick
   import rr_arb_pkg::*;
(
   input  logic [N-1:0]     req_i,
   input  logic [IDX_W-1:0] start_i,
   input  logic [N-1:0]     mask_i,
   output logic             found_o,
   output logic [IDX_W-1:0] idx_o
);

   logic [N-1:0]     cand;
   logic [IDX_W-1:0] pos;

   assign cand = req_i & ~mask_i;

   // Scan farthest-to-nearest so the candidate closest to start overwrites the rest
   always_comb begin
      found_o = 1'b0;
      idx_o   = '0;
      pos     = '0;
      for (int k = int'(N) - 1; k >= 0; k--) begin
         pos = start_i + IDX_W'(k);
         if (cand[pos]) begin
            found_o = 1'b1;
            idx_o   = pos;
         end
      end
   end

endmodule

// File: rtl/rr_arbiter8.sv
// 8-requester round-robin arbiter with registered grant, index and tenure-limit preemption.
module rr_arbiter8
   import rr_arb_pkg::*;
#(
   parameter int unsigned MAX_HOLD = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [N-1:0]     req,
   output logic [N-1:0]     gnt,
   output logic [IDX_W-1:0] gnt_idx,
   output logic             gnt_vld,
   output logic             preempt
);

   // A zero limit still needs a legal one-bit counter; it simply never advances
   localparam int unsigned    TEN_W     = (MAX_HOLD == 0) ? 1 : $clog2(MAX_HOLD + 1);
   localparam logic [TEN_W-1:0] HOLD_LAST = TEN_W'((MAX_HOLD == 0) ? 0 : MAX_HOLD - 1);

   state_e           state_q;
   logic [N-1:0]     gnt_q;
   logic [IDX_W-1:0] gnt_idx_q;
   logic             gnt_vld_q;
   logic             preempt_q;
   logic [IDX_W-1:0] ptr_q;
   logic [TEN_W-1:0] tenure_q;

   logic [IDX_W-1:0] pick_start;
   logic [N-1:0]     pick_mask;
   logic             pick_found;
   logic [IDX_W-1:0] pick_idx;
   logic [IDX_W-1:0] next_ptr;
   logic             owner_req;
   logic             expired;

   // Idle arbitration starts at the fairness pointer; busy arbitration starts past the owner
   always_comb begin
      pick_start = ptr_q;
      pick_mask  = '0;
      if (state_q == BUSY) begin
         pick_start = next_ptr;
         pick_mask  = onehot(gnt_idx_q);
      end
   end

   assign next_ptr  = gnt_idx_q + IDX_W'(1);
   assign owner_req = req[gnt_idx_q];
   assign expired   = (MAX_HOLD != 0) && (tenure_q == HOLD_LAST);

   rr_pick u_pick (
      .req_i   (req),
      .start_i (pick_start),
      .mask_i  (pick_mask),
      .found_o (pick_found),
      .idx_o   (pick_idx)
   );

   // Grant FSM: acquire from idle, hold while requested, hand over on release or expiry
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         gnt_q     <= '0;
         gnt_idx_q <= '0;
         gnt_vld_q <= 1'b0;
         preempt_q <= 1'b0;
         ptr_q     <= '0;
         tenure_q  <= '0;
      end else begin
         preempt_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (pick_found) begin
                  gnt_q     <= onehot(pick_idx);
                  gnt_idx_q <= pick_idx;
                  gnt_vld_q <= 1'b1;
                  tenure_q  <= '0;
                  state_q   <= BUSY;
               end
            end
            BUSY: begin
               if (!owner_req) begin
                  // Release wins over a coincident expiry, so no preempt here
                  ptr_q    <= next_ptr;
                  tenure_q <= '0;
                  if (pick_found) begin
                     gnt_q     <= onehot(pick_idx);
                     gnt_idx_q <= pick_idx;
                  end else begin
                     gnt_q     <= '0;
                     gnt_vld_q <= 1'b0;
                     state_q   <= IDLE;
                  end
               end else if (expired && pick_found) begin
                  gnt_q     <= onehot(pick_idx);
                  gnt_idx_q <= pick_idx;
                  ptr_q     <= next_ptr;
                  tenure_q  <= '0;
                  preempt_q <= 1'b1;
               end else if ((MAX_HOLD != 0) && (tenure_q != HOLD_LAST)) begin
                  tenure_q <= tenure_q + TEN_W'(1);
               end
            end
            default: begin
               state_q <= IDLE;
            end
         endcase
      end
   end

   assign gnt     = gnt_q;
   assign gnt_idx = gnt_idx_q;
   assign gnt_vld = gnt_vld_q;
   assign preempt = preempt_q;

endmodule
